// File: rtl/password_lock_pkg.sv
// Shared types and helpers for the programmable password lock.
package password_lock_pkg;

  typedef enum logic [2:0] {
    StProg  = 3'd0,
    StArmed = 3'd1,
    StCheck = 3'd2,
    StOpen  = 3'd3,
    StBoom  = 3'd4
  } state_e;

  localparam logic MODE_PROGRAMMING = 1'b0;
  localparam logic MODE_UNLOCKING   = 1'b1;

  // Thermometer code of count, clamped to four lit segments.
  function automatic logic [3:0] therm4(input int unsigned count);
    if (count >= 4) return 4'b1111;
    return 4'((32'd1 << count) - 32'd1);
  endfunction

endpackage

// File: rtl/password_lock_key_buffer.sv
// Append-only key symbol store with a saturating write pointer and an indexed read port.
module key_buffer #(
  parameter int unsigned KEY_W   = 2,
  parameter int unsigned MAX_LEN = 8,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1),
  localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             wr,
  input  logic [KEY_W-1:0] wr_data,
  input  logic             clr,
  input  logic [LEN_W-1:0] rd_idx,
  output logic [KEY_W-1:0] rd_data,
  output logic [LEN_W-1:0] len
);

  logic [KEY_W-1:0] mem_q [MAX_LEN];
  logic [LEN_W-1:0] len_q;
  logic             full;
  logic             do_wr;

  assign full  = (len_q == LEN_W'(MAX_LEN));
  assign do_wr = wr && !clr && !full;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      len_q <= '0;
    end else if (clr) begin
      len_q <= '0;
    end else if (do_wr) begin
      len_q <= len_q + 1'b1;
    end
  end

  // Contents need no reset: nothing is read beyond the valid length.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[len_q[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = (rd_idx < LEN_W'(MAX_LEN)) ? mem_q[rd_idx[IDX_W-1:0]] : '0;
  assign len     = len_q;

endmodule

// File: rtl/password_lock.sv
// Programmable key-sequence lock: stores a password, checks attempts one symbol per cycle,
// counts failures and latches explode after the allowed number of tries.
module password_lock
  import password_lock_pkg::*;
#(
  parameter int unsigned NUM_KEYS  = 3,
  parameter int unsigned MAX_LEN   = 8,
  parameter int unsigned MAX_TRIES = 3,
  localparam int unsigned KEY_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1),
  localparam int unsigned TRY_W    = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             mode,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  input  logic             enter,
  output logic             unlocked,
  output logic             explode,
  output logic [3:0]       led,
  output logic             busy
);

  localparam logic [KEY_W:0] NUM_KEYS_W = NUM_KEYS[KEY_W:0];

  state_e           state_q, state_d;
  logic [LEN_W-1:0] plen_q, plen_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] miss_q, miss_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [3:0]       led_q, led_d;

  logic             prog_wr, prog_clr, att_wr, att_clr;
  logic [KEY_W-1:0] prog_rd, att_rd;
  logic [LEN_W-1:0] plen_wr, alen;
  logic             key_ok;
  logic [LEN_W-1:0] check_len;
  logic             last_idx;
  logic             pos_miss;
  logic [LEN_W-1:0] miss_total;
  logic [TRY_W-1:0] tries_inc;

  key_buffer #(
    .KEY_W   (KEY_W),
    .MAX_LEN (MAX_LEN)
  ) u_prog_buf (
    .clk        (clk),
    .sync_reset (sync_reset),
    .wr         (prog_wr),
    .wr_data    (key_code),
    .clr        (prog_clr),
    .rd_idx     (idx_q),
    .rd_data    (prog_rd),
    .len        (plen_wr)
  );

  key_buffer #(
    .KEY_W   (KEY_W),
    .MAX_LEN (MAX_LEN)
  ) u_att_buf (
    .clk        (clk),
    .sync_reset (sync_reset),
    .wr         (att_wr),
    .wr_data    (key_code),
    .clr        (att_clr),
    .rd_idx     (idx_q),
    .rd_data    (att_rd),
    .len        (alen)
  );

  assign key_ok     = key_valid && ({1'b0, key_code} < NUM_KEYS_W);
  assign check_len  = (plen_q > alen) ? plen_q : alen;
  assign last_idx   = (idx_q == check_len - 1'b1);
  // Positions past either sequence's end always count as a miss.
  assign pos_miss   = (idx_q >= plen_q) || (idx_q >= alen) || (prog_rd != att_rd);
  assign miss_total = miss_q + LEN_W'(pos_miss);
  assign tries_inc  = tries_q + 1'b1;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= StProg;
      plen_q  <= '0;
      idx_q   <= '0;
      miss_q  <= '0;
      tries_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      plen_q  <= plen_d;
      idx_q   <= idx_d;
      miss_q  <= miss_d;
      tries_q <= tries_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    plen_d   = plen_q;
    idx_d    = idx_q;
    miss_d   = miss_q;
    tries_d  = tries_q;
    led_d    = led_q;
    prog_wr  = 1'b0;
    prog_clr = 1'b0;
    att_wr   = 1'b0;
    att_clr  = 1'b0;
    unique case (state_q)
      StProg: begin
        if (mode == MODE_UNLOCKING) begin
          if (plen_q != '0) state_d = StArmed;
        end else if (enter) begin
          if (plen_wr != '0) begin
            plen_d   = plen_wr;
            prog_clr = 1'b1;
            tries_d  = '0;
          end
        end else if (key_ok) begin
          prog_wr = 1'b1;
        end
      end
      StArmed: begin
        if (mode == MODE_PROGRAMMING) begin
          state_d = StProg;
          att_clr = 1'b1;
          led_d   = '0;
          tries_d = '0;
        end else if (enter) begin
          if (alen != '0) begin
            state_d = StCheck;
            idx_d   = '0;
            miss_d  = '0;
          end
        end else if (key_ok) begin
          att_wr = 1'b1;
          led_d  = '0;
        end
      end
      StCheck: begin
        idx_d  = idx_q + 1'b1;
        miss_d = miss_total;
        if (last_idx) begin
          att_clr = 1'b1;
          if (miss_total == '0) begin
            state_d = StOpen;
          end else begin
            tries_d = tries_inc;
            if (tries_inc == TRY_W'(MAX_TRIES)) begin
              state_d = StBoom;
              led_d   = 4'b1111;
            end else begin
              state_d = StArmed;
              led_d   = therm4(32'(miss_total));
            end
          end
        end
      end
      StOpen: begin
        if (mode == MODE_PROGRAMMING) begin
          state_d = StProg;
          tries_d = '0;
        end
      end
      StBoom:  state_d = StBoom;
      default: state_d = StProg;
    endcase
  end

  assign unlocked = (state_q == StOpen);
  assign explode  = (state_q == StBoom);
  assign busy     = (state_q == StCheck);
  assign led      = led_q;

endmodule

// File: tb/tb_password_lock.sv
// Directed scoreboard bench: a default lock (3 keys, 8 symbols) and a wide one (5 keys, 16).
module tb_password_lock;
  import password_lock_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       sync_reset = 1'b0;
  logic       a_mode = 1'b0, a_key_valid = 1'b0, a_enter = 1'b0;
  logic [1:0] a_key_code = '0;
  logic       a_unlocked, a_explode, a_busy;
  logic [3:0] a_led;
  logic       b_mode = 1'b0, b_key_valid = 1'b0, b_enter = 1'b0;
  logic [2:0] b_key_code = '0;
  logic       b_unlocked, b_explode, b_busy;
  logic [3:0] b_led;

  password_lock dut_a (
    .clk        (clk),
    .sync_reset (sync_reset),
    .mode       (a_mode),
    .key_valid  (a_key_valid),
    .key_code   (a_key_code),
    .enter      (a_enter),
    .unlocked   (a_unlocked),
    .explode    (a_explode),
    .led        (a_led),
    .busy       (a_busy)
  );

  password_lock #(
    .NUM_KEYS (5),
    .MAX_LEN  (16)
  ) dut_b (
    .clk        (clk),
    .sync_reset (sync_reset),
    .mode       (b_mode),
    .key_valid  (b_key_valid),
    .key_code   (b_key_code),
    .enter      (b_enter),
    .unlocked   (b_unlocked),
    .explode    (b_explode),
    .led        (b_led),
    .busy       (b_busy)
  );

  typedef struct {
    string      tag;
    logic       unlocked;
    logic       explode;
    logic [3:0] led;
    int         busy_cycles;
  } exp_t;

  exp_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int which, input int k);
    if (which == 0) begin a_key_valid = 1'b1; a_key_code = 2'(k); end
    else begin b_key_valid = 1'b1; b_key_code = 3'(k); end
    tick();
    a_key_valid = 1'b0;
    b_key_valid = 1'b0;
  endtask

  task automatic press_and_enter(input int which, input int k);
    if (which == 0) begin a_key_valid = 1'b1; a_key_code = 2'(k); a_enter = 1'b1; end
    else begin b_key_valid = 1'b1; b_key_code = 3'(k); b_enter = 1'b1; end
    tick();
    a_key_valid = 1'b0; a_enter = 1'b0;
    b_key_valid = 1'b0; b_enter = 1'b0;
  endtask

  task automatic hit_enter(input int which);
    if (which == 0) a_enter = 1'b1;
    else b_enter = 1'b1;
    tick();
    a_enter = 1'b0;
    b_enter = 1'b0;
  endtask

  task automatic set_mode(input int which, input logic m);
    if (which == 0) a_mode = m;
    else b_mode = m;
    tick();
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    tick();
    tick();
    sync_reset = 1'b0;
  endtask

  task automatic push_exp(input string tag, input logic u, input logic x, input logic [3:0] l,
                          input int n);
    exp_t e;
    e.tag = tag; e.unlocked = u; e.explode = x; e.led = l; e.busy_cycles = n;
    sb.push_back(e);
  endtask

  // Enter is accepted at the next edge; count busy cycles, then compare the settled result.
  task automatic run_check(input int which);
    exp_t e;
    int   n;
    n = 0;
    hit_enter(which);
    while (((which == 0) ? a_busy : b_busy) && n < 100) begin
      n++;
      tick();
    end
    e = sb.pop_front();
    check({e.tag, ".busy_cycles"}, n, e.busy_cycles);
    check({e.tag, ".unlocked"}, (which == 0) ? a_unlocked : b_unlocked, e.unlocked);
    check({e.tag, ".explode"}, (which == 0) ? a_explode : b_explode, e.explode);
    check({e.tag, ".led"}, (which == 0) ? a_led : b_led, e.led);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_b [16];
    #1;
    do_reset();
    check("rst.unlocked", a_unlocked, 1'b0);
    check("rst.explode", a_explode, 1'b0);
    check("rst.busy", a_busy, 1'b0);
    check("rst.led", a_led, 4'b0000);
    check("rst.state", 32'(dut_a.state_q), 32'(StProg));

    // Program 0,1,2,1 and unlock with the same sequence.
    press(0, 0); press(0, 1); press(0, 2); press(0, 1);
    hit_enter(0);
    check("prog.plen", 32'(dut_a.plen_q), 32'd4);
    set_mode(0, MODE_UNLOCKING);
    check("arm.state", 32'(dut_a.state_q), 32'(StArmed));
    press(0, 0); press(0, 1); press(0, 2); press(0, 1);
    push_exp("good", 1'b1, 1'b0, 4'b0000, 4);
    run_check(0);

    // Two symbol mismatches; invalid code 3 in the middle is ignored.
    set_mode(0, MODE_PROGRAMMING);
    set_mode(0, MODE_UNLOCKING);
    press(0, 0); press(0, 1); press(0, 3); press(0, 0); press(0, 0);
    push_exp("wrong1", 1'b0, 1'b0, 4'b0011, 4);
    run_check(0);
    check("wrong1.tries", 32'(dut_a.tries_q), 32'd1);
    check("wrong1.state", 32'(dut_a.state_q), 32'(StArmed));
    press(0, 0);
    check("ledclr", a_led, 4'b0000);

    // Short attempt 0,1: two misses from the length difference.
    press(0, 1);
    push_exp("short", 1'b0, 1'b0, 4'b0011, 4);
    run_check(0);
    check("short.tries", 32'(dut_a.tries_q), 32'd2);

    // Third failure explodes; everything but reset is then ignored.
    press(0, 2); press(0, 2); press(0, 2); press(0, 2);
    push_exp("boom", 1'b0, 1'b1, 4'b1111, 4);
    run_check(0);
    set_mode(0, MODE_PROGRAMMING);
    press(0, 0);
    hit_enter(0);
    set_mode(0, MODE_UNLOCKING);
    check("boom.sticky", a_explode, 1'b1);
    check("boom.led", a_led, 4'b1111);
    check("boom.state", 32'(dut_a.state_q), 32'(StBoom));
    do_reset();
    check("boom.rst.explode", a_explode, 1'b0);
    check("boom.rst.plen", 32'(dut_a.plen_q), 32'd0);
    check("boom.rst.state", 32'(dut_a.state_q), 32'(StProg));

    // Unlock mode with no password stays in programming.
    tick();
    check("noplen.state", 32'(dut_a.state_q), 32'(StProg));
    check("noplen.unlocked", a_unlocked, 1'b0);
    set_mode(0, MODE_PROGRAMMING);

    // Ten presses saturate at eight; simultaneous key+enter drops the key.
    press(0, 0); press(0, 1); press(0, 2); press(0, 0); press(0, 1);
    press(0, 2); press(0, 0); press(0, 1); press(0, 2); press(0, 2);
    hit_enter(0);
    check("sat.plen", 32'(dut_a.plen_q), 32'd8);
    press_and_enter(0, 2);
    check("simul.plen_wr", 32'(dut_a.plen_wr), 32'd0);
    check("simul.plen", 32'(dut_a.plen_q), 32'd8);
    set_mode(0, MODE_UNLOCKING);
    press(0, 0); press(0, 1); press(0, 2); press(0, 0);
    press(0, 1); press(0, 2); press(0, 0); press(0, 1);
    push_exp("sat.good", 1'b1, 1'b0, 4'b0000, 8);
    run_check(0);

    // Eighth key arrives with enter: enter wins, the attempt is one short.
    set_mode(0, MODE_PROGRAMMING);
    set_mode(0, MODE_UNLOCKING);
    press(0, 0); press(0, 1); press(0, 2); press(0, 0);
    press(0, 1); press(0, 2); press(0, 0);
    a_key_valid = 1'b1; a_key_code = 2'd1;
    push_exp("simul.att", 1'b0, 1'b0, 4'b0001, 8);
    run_check(0);
    check("simul.att.tries", 32'(dut_a.tries_q), 32'd1);

    // Wide lock: 16 keys including code 4; code 7 is ignored.
    for (int i = 0; i < 16; i++) seq_b[i] = (i * 3) % 5;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) press(1, 7);
      press(1, seq_b[i]);
    end
    hit_enter(1);
    check("wide.plen", 32'(dut_b.plen_q), 32'd16);
    set_mode(1, MODE_UNLOCKING);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) press(1, 7);
      press(1, seq_b[i]);
    end
    push_exp("wide.good", 1'b1, 1'b0, 4'b0000, 16);
    run_check(1);

    check("sb.empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
